// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, word width
// and the default sequential PC increment.
package fetch_unit_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one memory request, waits
// for the response, holds the word for decode and computes the next PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] next_pc,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc
);

    fetch_state_t state;
    fetch_state_t state_n;
    logic         discard;
    logic         discard_n;
    logic         capture;

    assign imem_req_addr = pc;

    // Redirect beats the sequential increment; instr_valid is high exactly in HOLD.
    always_comb begin
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (instr_valid && instr_ready) begin
            next_pc = pc + WORD_W'(PC_STEP);
        end else begin
            next_pc = pc;
        end
    end

    always_comb begin
        state_n   = state;
        discard_n = discard;
        capture   = 1'b0;
        case (state)
            ST_REQ: begin
                if (discard) begin
                    if (imem_rsp_valid) begin
                        discard_n = 1'b0;
                    end
                end else if (imem_req_valid && imem_req_ready) begin
                    state_n = ST_WAIT;
                    if (redirect_valid) begin
                        discard_n = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A response landing with the redirect settles the request, so
                // it is dropped here instead of waiting for another one.
                if (redirect_valid) begin
                    if (!imem_rsp_valid) begin
                        discard_n = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    state_n = ST_HOLD;
                    capture = 1'b1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    state_n = ST_REQ;
                end
            end
            default: begin
                state_n = ST_REQ;
            end
        endcase
        if (redirect_valid) begin
            state_n = ST_REQ;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_REQ;
            discard        <= 1'b0;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
        end else begin
            state          <= state_n;
            discard        <= discard_n;
            imem_req_valid <= (state_n == ST_REQ) && !discard_n;
            instr_valid    <= (state_n == ST_HOLD);
            if (capture) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural PC register.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .next_pc        (next_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) pc <= next_pc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] exp_pc, input logic [31:0] data);
        int n = 0;
        imem_req_ready = 1'b1;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_timeout: imem_req_valid=%b, required 1 within 10 cycles", imem_req_valid);
            imem_req_ready = 1'b0;
            return;
        end
        checks++;
        if (imem_req_addr !== exp_pc) begin
            errors++;
            $display("[TB] FAIL req_addr: got %h, required %h", imem_req_addr, exp_pc);
        end
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL instr_valid: got %b, required 1", instr_valid);
        end
        checks++;
        if (instr !== data) begin
            errors++;
            $display("[TB] FAIL instr: got %h, required %h", instr, data);
        end
        checks++;
        if (instr_pc !== exp_pc) begin
            errors++;
            $display("[TB] FAIL instr_pc: got %h, required %h", instr_pc, exp_pc);
        end
    endtask

    task automatic consume(input logic [31:0] exp_next);
        instr_ready = 1'b1;
        #1;
        checks++;
        if (next_pc !== exp_next) begin
            errors++;
            $display("[TB] FAIL consume_next_pc: got %h, required %h", next_pc, exp_next);
        end
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL consume_instr_valid: got %b, required 0", instr_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (next_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_next_pc: got %h, required 0", next_pc); end
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_instr: valid=%b instr=%h instr_pc=%h, required 0/0/0", instr_valid, instr, instr_pc);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL first_req: req_valid=%b pc=%h, required 1 and 0", imem_req_valid, pc);
        end
    endtask

    task automatic test_sequential();
        fetch_word(32'h0, 32'h0000_0013);
        consume(32'h4);
        fetch_word(32'h4, 32'h0040_0093);
        consume(32'h8);
        fetch_word(32'h8, 32'h0080_0113);
        consume(32'hC);
    endtask

    task automatic test_hold_stall();
        fetch_word(32'hC, 32'h00C0_0193);
        for (int i = 0; i < 5; i++) begin
            // A stray response while holding must not disturb the held word.
            imem_rsp_valid = (i == 2);
            imem_rsp_data  = (i == 2) ? 32'hFFFF_FFFF : 32'h0;
            #1;
            checks++;
            if (next_pc !== 32'hC) begin
                errors++;
                $display("[TB] FAIL stall_next_pc: cycle %0d got %h, required 0000000c", i, next_pc);
            end
            tick();
            imem_rsp_valid = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h00C0_0193 || instr_pc !== 32'hC || pc !== 32'hC) begin
                errors++;
                $display("[TB] FAIL stall_stable: cycle %0d valid=%b instr=%h instr_pc=%h pc=%h, required 1/00c00193/c/c",
                         i, instr_valid, instr, instr_pc, pc);
            end
        end
        consume(32'h10);
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        #1;
        checks++;
        if (next_pc !== 32'h100) begin errors++; $display("[TB] FAIL wait_redirect_next_pc: got %h, required 00000100", next_pc); end
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL discard_req: req_valid=%b pc=%h, required 0 and 00000100", imem_req_valid, pc);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_rsp_drop: instr_valid=%b req_valid=%b, required 0 and 1", instr_valid, imem_req_valid);
        end
        fetch_word(32'h100, 32'h1000_0513);
        consume(32'h104);
    endtask

    task automatic test_redirect_hold();
        fetch_word(32'h104, 32'h1040_0593);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        #1;
        checks++;
        if (next_pc !== 32'h40) begin errors++; $display("[TB] FAIL hold_redirect_next_pc: got %h, required 00000040", next_pc); end
        tick();
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 32'h40 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_redirect: instr_valid=%b pc=%h req_valid=%b, required 0/00000040/1",
                     instr_valid, pc, imem_req_valid);
        end
        fetch_word(32'h40, 32'h0400_0613);
        consume(32'h44);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_word(32'hFFFF_FFFC, 32'hFFC0_0693);
        consume(32'h0);
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h, required 00000000", pc); end
    endtask

    task automatic test_reset_in_wait();
        fetch_word(32'h0, 32'h0000_0713);
        consume(32'h4);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || next_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset: req=%b valid=%b instr=%h instr_pc=%h next_pc=%h, required all 0",
                     imem_req_valid, instr_valid, instr, instr_pc, next_pc);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rsp_in_reset: valid=%b instr=%h pc=%h, required 0/0/0", instr_valid, instr, pc);
        end
        reset = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_req: valid=%b req=%b addr=%h, required 0/1/00000000",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
        fetch_word(32'h0, 32'h0000_0013);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address driven on next_pc while reset is asserted.
REQ-002 Parameter PC_STEP, default 4, sequential instruction increment in bytes.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  current program counter, from the PC register.
REQ-006 next_pc  output  32  value the PC register loads on the next posedge; combinational from state and inputs.
REQ-007 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-008 redirect_target  input  32  redirect destination, sampled when redirect_valid=1.
REQ-009 imem_req_valid / imem_req_ready  output / input  1 / 1  instruction-memory request handshake.
REQ-010 imem_req_addr  output  32  request address, equal to pc while imem_req_valid=1.
REQ-011 imem_rsp_valid / imem_rsp_data  input / input  1 / 32  memory response, one-cycle pulse with data.
REQ-012 instr_valid / instr_ready  output / input  1 / 1  instruction handshake to decode.
REQ-013 instr / instr_pc  output / output  32 / 32  fetched word and the address it was fetched from.

Function
REQ-014 The FSM SHALL have states REQ, WAIT and HOLD.
- REQ: imem_req_valid=1; on imem_req_ready=1, go to WAIT.
- WAIT: on imem_rsp_valid=1, capture data into instr and pc into instr_pc, then go to HOLD.
- HOLD: instr_valid=1; on instr_ready=1, go to REQ.
REQ-015 next_pc SHALL equal pc in every cycle except the HOLD-and-instr_ready cycle, where it equals pc+PC_STEP (mod 2^32, wrap silently).
REQ-016 redirect_valid=1 in any state SHALL set next_pc=redirect_target and force the FSM to REQ on the next cycle.
- Redirect has priority over increment.
REQ-017 A redirect in REQ with imem_req_ready=1 in the same cycle SHALL still count the request as accepted.
- Set a discard flag; the matching response is dropped.
REQ-018 A redirect in WAIT SHALL set the discard flag; a response arriving in that same cycle is dropped.
REQ-019 While the discard flag is set, the FSM SHALL stay in REQ with imem_req_valid=0.
- The first subsequent imem_rsp_valid clears the flag and is not presented.
REQ-020 A redirect in HOLD SHALL deassert instr_valid next cycle, even if instr_ready=1 in the same cycle.
- No increment occurs in that case.
REQ-021 instr and instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-022 Throughput SHALL be at most one instruction per 3 cycles; latency from request acceptance to instr_valid is one cycle after imem_rsp_valid.
REQ-023 imem_rsp_valid outside WAIT or discard SHALL be ignored.
REQ-024 At most one memory request SHALL be outstanding.

Reset
REQ-025 While reset=1, the block SHALL drive:
- next_pc=RESET_PC; FSM=REQ; imem_req_valid=0; discard=0.
- instr_valid=0; instr=0; instr_pc=0.
REQ-026 After reset deasserts, imem_req_valid SHALL assert from the first posedge onward, by which time pc=RESET_PC.
REQ-027 Reset mid-transaction SHALL abandon any outstanding request; a late response is ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration, PC_STEP and the 32-bit word width constant.
REQ-029 The block SHALL be a single module with no sub-modules; the external PC register stays separate.

Verification
REQ-030 Reset, then ready=1 and responses one cycle after acceptance -> instr_pc sequence 0, 4, 8; instr matches memory.
REQ-031 instr_ready held 0 for 5 cycles in HOLD -> instr, instr_pc and pc stable; next_pc=pc.
REQ-032 Redirect to 0x100 while in WAIT, then late response 0xDEADBEEF -> word dropped; next instr_pc=0x100.
REQ-033 Redirect to 0x40 in HOLD with instr_ready=1 -> instruction not consumed; next_pc=0x40, not pc+4.
REQ-034 pc=0xFFFFFFFC consumed -> next_pc=0x00000000.
REQ-035 Reset asserted in WAIT, response arrives during reset -> outputs at reset values; first request after reset at RESET_PC.
